// File: rtl/shreg_pkg.sv
// Shared constants for the universal shift register: mode codes, burst FSM states, burst directions.
package shreg_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } burst_state_e;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

endpackage

// File: rtl/shreg_burst_ctrl.sv
// Burst engine: accepts START/DIR/LEN while idle and issues LEN back-to-back shift enables,
// then pulses DONE for one cycle.
module shreg_burst_ctrl
  import shreg_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] len,
  output logic             shift_en_c,
  output logic             shift_dir_c,
  output logic             busy,
  output logic             done
);

  burst_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_R;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            dir_d   = dir;
            cnt_d   = len;
            state_d = ST_RUN;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign shift_en_c  = (state_q == ST_RUN);
  assign shift_dir_c = dir_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = done_q;

endmodule

// File: rtl/shreg_univ_n.sv
// WIDTH-bit universal shift register (hold/shift/load/rotate/clear) with a burst shift engine.
// Rotate modes are built only when SHREG_ROTATE_EN is defined; otherwise they hold.
module shreg_univ_n
  import shreg_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CP,
  input  logic             CR,
  input  logic [2:0]       S,
  input  logic [WIDTH-1:0] D,
  input  logic             DSR,
  input  logic             DSL,
  input  logic             START,
  input  logic             DIR,
  input  logic [CNT_W-1:0] LEN,
  output logic [WIDTH-1:0] Q,
  output logic             SO_R,
  output logic             SO_L,
  output logic             BUSY,
  output logic             DONE
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] shr_c, shl_c;
  logic             shift_en_c, shift_dir_c;

  shreg_burst_ctrl #(
    .CNT_W (CNT_W)
  ) u_burst_ctrl (
    .clk         (CP),
    .rst         (CR),
    .start       (START),
    .dir         (DIR),
    .len         (LEN),
    .shift_en_c  (shift_en_c),
    .shift_dir_c (shift_dir_c),
    .busy        (BUSY),
    .done        (DONE)
  );

  assign shr_c = {q_q[WIDTH-2:0], DSR};
  assign shl_c = {DSL, q_q[WIDTH-1:1]};

  // Burst shifts win; S is only decoded when idle with no START (START edge holds Q).
  always_comb begin
    q_d = q_q;
    if (shift_en_c) begin
      q_d = (shift_dir_c == DIR_L) ? shl_c : shr_c;
    end else if (!BUSY && !START) begin
      case (S)
        MODE_SHR:  q_d = shr_c;
        MODE_SHL:  q_d = shl_c;
        MODE_LOAD: q_d = D;
`ifdef SHREG_ROTATE_EN
        MODE_ROR:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROL:  q_d = {q_q[0], q_q[WIDTH-1:1]};
`endif
        MODE_CLR:  q_d = '0;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) q_q <= '0;
    else    q_q <= q_d;
  end

  assign Q    = q_q;
  assign SO_R = q_q[WIDTH-1];
  assign SO_L = q_q[0];

endmodule

// File: tb/tb_shreg_univ_n.sv
// Directed testbench for shreg_univ_n (WIDTH=8); rotate expectations follow SHREG_ROTATE_EN.
module tb_shreg_univ_n;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             CP = 1'b0;
  logic             CR = 1'b1;
  logic [2:0]       S = 3'b000;
  logic [WIDTH-1:0] D = '0;
  logic             DSR = 1'b0;
  logic             DSL = 1'b0;
  logic             START = 1'b0;
  logic             DIR = 1'b0;
  logic [CNT_W-1:0] LEN = '0;
  logic [WIDTH-1:0] Q;
  logic             SO_R, SO_L, BUSY, DONE;

  int n_checks = 0;
  int n_fail   = 0;

  shreg_univ_n #(.WIDTH(WIDTH)) dut (
    .CP(CP), .CR(CR), .S(S), .D(D), .DSR(DSR), .DSL(DSL),
    .START(START), .DIR(DIR), .LEN(LEN),
    .Q(Q), .SO_R(SO_R), .SO_L(SO_L), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CP = ~CP;

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    S = 3'b011; D = v;
    tick();
    S = 3'b000;
  endtask

  task automatic chk(input string name, input logic [WIDTH-1:0] q_exp,
                     input logic busy_exp, input logic done_exp);
    n_checks++;
    if (Q !== q_exp || BUSY !== busy_exp || DONE !== done_exp) begin
      n_fail++;
      $display("FAIL %s: got Q=%b BUSY=%b DONE=%b, want Q=%b BUSY=%b DONE=%b",
               name, Q, BUSY, DONE, q_exp, busy_exp, done_exp);
    end
  endtask

  task automatic test_reset();
    #12;
    chk("reset_state", 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (SO_R !== 1'b0 || SO_L !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_so: got SO_R=%b SO_L=%b, want 0 0", SO_R, SO_L);
    end
    @(posedge CP); #1;
    CR = 1'b0;
  endtask

  task automatic test_load();
    load(8'b1010_0101);
    chk("load_a5", 8'b1010_0101, 1'b0, 1'b0);
    n_checks++;
    if (SO_R !== 1'b1 || SO_L !== 1'b1) begin
      n_fail++;
      $display("FAIL load_so: got SO_R=%b SO_L=%b, want 1 1", SO_R, SO_L);
    end
    tick();
    chk("hold_000", 8'b1010_0101, 1'b0, 1'b0);
    S = 3'b110;
    tick();
    chk("hold_110", 8'b1010_0101, 1'b0, 1'b0);
    S = 3'b111;
    tick();
    chk("clear", 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_shift();
    S = 3'b001; DSR = 1'b1;
    repeat (3) tick();
    chk("shr_x3", 8'b0000_0111, 1'b0, 1'b0);
    S = 3'b010; DSL = 1'b0; DSR = 1'b0;
    repeat (2) tick();
    chk("shl_x2", 8'b0000_0001, 1'b0, 1'b0);
    DSL = 1'b1;
    tick();
    chk("shl_fill", 8'b1000_0000, 1'b0, 1'b0);
    S = 3'b000;
  endtask

  task automatic test_rotate();
    load(8'b1000_0001);
    S = 3'b100;
    tick();
`ifdef SHREG_ROTATE_EN
    chk("ror", 8'b0000_0011, 1'b0, 1'b0);
`else
    chk("ror_hold", 8'b1000_0001, 1'b0, 1'b0);
`endif
    S = 3'b101;
    tick();
    chk("rol", 8'b1000_0001, 1'b0, 1'b0);
    S = 3'b000;
  endtask

  task automatic test_burst();
    load(8'b1111_0000);
    START = 1'b1; DIR = 1'b0; LEN = 4'd3; DSR = 1'b0; S = 3'b011; D = 8'hFF;
    tick();
    chk("burst_accept", 8'b1111_0000, 1'b1, 1'b0);
    START = 1'b0; S = 3'b111;
    tick();
    chk("burst_sh1", 8'b1110_0000, 1'b1, 1'b0);
    S = 3'b001; DSR = 1'b0;
    tick();
    chk("burst_sh2", 8'b1100_0000, 1'b1, 1'b0);
    S = 3'b011;
    tick();
    chk("burst_done", 8'b1000_0000, 1'b0, 1'b1);
    S = 3'b000;
    tick();
    chk("burst_after", 8'b1000_0000, 1'b0, 1'b0);
  endtask

  task automatic test_len_zero();
    START = 1'b1; LEN = 4'd0; DIR = 1'b1; DSL = 1'b1;
    tick();
    chk("len0_done", 8'b1000_0000, 1'b0, 1'b1);
    START = 1'b0;
    tick();
    chk("len0_after", 8'b1000_0000, 1'b0, 1'b0);
  endtask

  task automatic test_long_burst();
    START = 1'b1; DIR = 1'b1; LEN = 4'd10; DSL = 1'b1;
    tick();
    START = 1'b0;
    repeat (8) tick();
    chk("long_sh8", 8'hFF, 1'b1, 1'b0);
    tick();
    chk("long_sh9", 8'hFF, 1'b1, 1'b0);
    tick();
    chk("long_done", 8'hFF, 1'b0, 1'b1);
  endtask

  task automatic test_start_busy_and_back_to_back();
    START = 1'b1; DIR = 1'b0; LEN = 4'd2; DSR = 1'b0;
    tick();
    chk("sb_accept", 8'hFF, 1'b1, 1'b0);
    DIR = 1'b1; LEN = 4'd5; DSL = 1'b1;
    tick();
    chk("sb_ignored", 8'b1111_1110, 1'b1, 1'b0);
    tick();
    chk("sb_done", 8'b1111_1100, 1'b0, 1'b1);
    DIR = 1'b1; LEN = 4'd1; DSL = 1'b0;
    tick();
    chk("b2b_accept", 8'b1111_1100, 1'b1, 1'b0);
    START = 1'b0;
    tick();
    chk("b2b_done", 8'b0111_1110, 1'b0, 1'b1);
    tick();
    chk("b2b_after", 8'b0111_1110, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    START = 1'b1; DIR = 1'b0; LEN = 4'd5; DSR = 1'b1;
    tick();
    START = 1'b0;
    repeat (2) tick();
    chk("rmb_running", 8'b1111_1011, 1'b1, 1'b0);
    #2 CR = 1'b1;
    #1;
    chk("rmb_async", 8'h00, 1'b0, 1'b0);
    tick();
    CR = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rmb_no_done", 8'h00, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift();
    test_rotate();
    test_burst();
    test_len_zero();
    test_long_burst();
    test_start_busy_and_back_to_back();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shreg_univ_n.md
# shreg_univ_n

Parametrised universal shift register: the WIDTH-bit generalisation of our 4-bit 74194-style register. It keeps hold, shift-right, shift-left and parallel-load. It adds rotate modes, a synchronous clear, serial-out taps, and an autonomous burst engine that performs LEN back-to-back shifts after a START handshake. It sits in serializer/deserializer and LED/scan-chain paths, driven either cycle-by-cycle via S or in bursts.

## Interface
- WIDTH, 8: register width in bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH+1): derived local parameter; width of LEN and of the burst counter.
- CP  in  1: clock; all state changes on the rising edge.
- CR  in  1: reset; asynchronous and active-high.
- S  in  3: mode select; sampled only when idle.
- D  in  WIDTH: parallel load data.
- DSR  in  1: serial input for right shift, entering Q[0].
- DSL  in  1: serial input for left shift, entering Q[WIDTH-1].
- START  in  1: burst request; sampled only when idle.
- DIR  in  1: burst direction, sampled with START; 0 = right, 1 = left.
- LEN  in  CNT_W: burst shift count, sampled with START.
- Q  out  WIDTH: register contents.
- SO_R  out  1: Q[WIDTH-1], the bit shifted out by a right shift.
- SO_L  out  1: Q[0], the bit shifted out by a left shift.
- BUSY  out  1: burst in progress.
- DONE  out  1: one-cycle pulse at burst completion.

## Operation
- Right shift: Q[0]←DSR; Q[i]←Q[i-1] for i ≥ 1.
- Left shift: Q[WIDTH-1]←DSL; Q[i]←Q[i+1].
- S decode when idle and START=0:
  - 000: hold.
  - 001: right shift.
  - 010: left shift.
  - 011: Q←D.
  - 100: rotate right, Q[0]←Q[WIDTH-1].
  - 101: rotate left, Q[WIDTH-1]←Q[0].
  - 110: hold (reserved).
  - 111: Q←0.
- FSM states:
  - IDLE: S decoded as above.
  - RUN: S ignored; one shift per edge in the latched direction; serial input is taken live from DSR or DSL on each edge.
- IDLE transitions when START=1:
  - LEN≠0: latch DIR, counter←LEN, go to RUN. Q holds on this edge; START has priority over S.
  - LEN=0: stay in IDLE, Q holds, DONE←1.
- RUN: shift and decrement the counter each edge. When the counter reaches 1, perform the final shift, go to IDLE and set DONE←1.
- LEN > WIDTH is legal. The extra shifts continue filling from the serial input.
- START while BUSY is ignored; no queuing.

## Timing
- Reset values: Q=0, BUSY=0, DONE=0, state IDLE, counter 0. SO_R and SO_L follow Q, so both are 0.
- CR asserted mid-burst aborts immediately; no DONE is produced.
- Single-cycle modes: Q updates on the same edge S is sampled (latency 1).
- Burst with START sampled at edge k and LEN=N>0:
  - Shifts occur on edges k+1 … k+N.
  - BUSY=1 after edge k through edge k+N, then 0.
  - DONE=1 for exactly the cycle after edge k+N.
- LEN=0: DONE=1 for the cycle after edge k; BUSY stays 0.
- A new START is accepted on the same edge that DONE is high (back-to-back bursts).
- SO_R and SO_L are combinational from Q; there is no extra latency.

## Configuration
- SHREG_ROTATE_EN defined: S=100/101 rotate as specified.
- SHREG_ROTATE_EN undefined: the rotate logic is absent and S=100/101 behave as hold. The burst engine is unaffected.

## Structure
- Package shreg_pkg holds:
  - mode constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_CLR;
  - FSM state encoding ST_IDLE, ST_RUN;
  - DIR constants DIR_R, DIR_L.
- One sub-module, shreg_burst_ctrl, contains the FSM, counter, BUSY and DONE. It outputs a per-cycle shift-enable and direction to the datapath in shreg_univ_n.

## Test plan
- Reset and load (WIDTH=8): CR=1 → Q=00000000, BUSY=0, DONE=0. Release CR; S=011, D=10100101 → Q=10100101 after one edge.
- Single-step shifts: from Q=0, S=001 with DSR=1 for 3 edges → Q=00000111. Then S=010 with DSL=0 for 2 edges → Q=00000001.
- Rotate: Q=10000001, S=100 → Q=00000011.
  - With SHREG_ROTATE_EN undefined, the same stimulus → Q=10000001 (hold).
- Burst: Q=11110000, START=1, DIR=0, LEN=3, DSR=0 → BUSY high 3 cycles, Q=10000000, DONE pulse 1 cycle after the third shift. S toggling during the burst has no effect.
- Edge cases:
  - LEN=0 → DONE pulse next cycle, BUSY=0, Q unchanged.
  - LEN=10 with DSL=1, DIR=1 → Q=11111111 after 10 shifts.
  - START during BUSY is ignored.
- Reset mid-burst: assert CR asynchronously between edges during LEN=5 → Q=0 and BUSY=0 immediately; no DONE pulse follows.
